// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch stage and the decoder.
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] instr_t;

    localparam instr_t RV_NOP = 32'h0000_0013;

    function automatic addr_t align_word(input addr_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

    // Sequential next-word address; wraps naturally at the top of memory.
    function automatic addr_t pc_step(input addr_t a);
        return a + addr_t'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/rv32i_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and redirect.
interface rv32i_fetch_if;
    import rv32i_pkg::*;

    logic   imem_req_valid;
    logic   imem_req_ready;
    addr_t  imem_addr;
    logic   imem_rsp_valid;
    instr_t imem_rsp_data;
    logic   instr_valid;
    logic   instr_ready;
    instr_t instruction;
    addr_t  pc;
    logic   redirect_valid;
    addr_t  redirect_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instruction, pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instruction, pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/rv32i_fetch_chk.sv
// Invariants of the fetch credit scheme.
module rv32i_fetch_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] out_cnt_i,
    input logic [CW-1:0] drop_cnt_i,
    input logic [CW-1:0] buf_cnt_i,
    input logic          push_i,
    input logic          pop_i
);

    credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, out_cnt_i} + {1'b0, buf_cnt_i}) <= (CW+1)'(DEPTH));

    drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt_i <= out_cnt_i);

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push_i && !pop_i) |-> (buf_cnt_i < CW'(DEPTH)));

endmodule

// File: rtl/rv32i_fetch_fifo.sv
// In-order instruction buffer, DEPTH x 32, with flush and occupancy output.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  instr_t                       data_i,
    output instr_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    instr_t        mem_q [DEPTH];
    logic          push_ok_s;
    logic          pop_ok_s;

    assign pop_ok_s  = pop_i & (count_q != {CW{1'b0}});
    assign push_ok_s = push_i & ((count_q != CNT_MAX) | pop_ok_s);

    // Pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Data storage needs no reset: entries are only visible once written.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = (count_q == {CW{1'b0}}) ? RV_NOP : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rv32i_fetch.sv
// RV32I fetch stage: credit-limited sequential fetch, in-order buffer, redirect flush.
module rv32i_fetch
    import rv32i_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter int    DEPTH    = 2
) (
    input logic          clk,
    input logic          rst_n,
    rv32i_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    addr_t         fetch_pc_q, fetch_pc_d;
    addr_t         head_pc_q, head_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] buf_cnt_s;
    logic [CW:0]   credit_s;
    logic          req_valid_s, req_fire_s, rsp_take_s;
    logic          instr_valid_s, push_s, pop_s;
    instr_t        head_s;

    // Dropped requests stay in out_cnt, so the credit also covers them.
    assign credit_s      = {1'b0, out_cnt_q} + {1'b0, buf_cnt_s};
    assign req_valid_s   = rst_n & ~bus.redirect_valid & (credit_s < (CW+1)'(DEPTH));
    assign req_fire_s    = req_valid_s & bus.imem_req_ready;
    assign rsp_take_s    = bus.imem_rsp_valid & (out_cnt_q != {CW{1'b0}});
    assign instr_valid_s = (buf_cnt_s != {CW{1'b0}}) & ~bus.redirect_valid;
    assign pop_s         = instr_valid_s & bus.instr_ready;
    assign push_s        = rsp_take_s & (drop_cnt_q == {CW{1'b0}}) & ~bus.redirect_valid;

    rv32i_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (bus.redirect_valid),
        .data_i  (bus.imem_rsp_data),
        .head_o  (head_s),
        .count_o (buf_cnt_s)
    );

    // Next-state for PCs and request counters; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = align_word(bus.redirect_pc);
            head_pc_d  = align_word(bus.redirect_pc);
            out_cnt_d  = out_cnt_q - CW'(rsp_take_s);
            drop_cnt_d = out_cnt_q - CW'(rsp_take_s);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = pc_step(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                head_pc_d = pc_step(head_pc_q);
            end else begin
                head_pc_d = head_pc_q;
            end
            out_cnt_d = out_cnt_q + CW'(req_fire_s) - CW'(rsp_take_s);
            if (rsp_take_s && (drop_cnt_q != {CW{1'b0}})) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            out_cnt_q  <= {CW{1'b0}};
            drop_cnt_q <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.instr_valid    = instr_valid_s;
    assign bus.instruction    = head_s;
    assign bus.pc             = head_pc_q;

    rv32i_fetch_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .out_cnt_i  (out_cnt_q),
        .drop_cnt_i (drop_cnt_q),
        .buf_cnt_i  (buf_cnt_s),
        .push_i     (push_s),
        .pop_i      (pop_s)
    );

endmodule

// File: tb/tb_rv32i_fetch.sv
// Scoreboard bench for rv32i_fetch: memory model, expected (pc, instr) stream, monitor.
module tb_rv32i_fetch;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam int          DEPTH  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32i_fetch_if bus ();

    rv32i_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    mreq_t       mq[$];
    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        stray = 1'b0;
    logic [31:0] model_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_1001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Instruction memory: in-order responses once each request's latency has elapsed.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0000_0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq.delete();
                bus.imem_rsp_valid = 1'b0;
            end else if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else if (stray) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = 32'hDEAD_BEEF;
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    // Request observer: the architectural fetch stream defines the expected deliveries.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_pc = RST_PC;
        end else if (bus.redirect_valid) begin
            exp_q.delete();
            model_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("imem_addr", bus.imem_addr, model_pc);
            exp_q.push_back('{model_pc, mem_word(model_pc)});
            mq.push_back('{bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            model_pc = model_pc + 32'd4;
            acc_cnt++;
        end
    end

    // Decode-side monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.redirect_valid) begin
                chk("instr_valid_masked", {31'd0, bus.instr_valid}, 32'd0);
                chk("req_valid_masked", {31'd0, bus.imem_req_valid}, 32'd0);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_instr: got pc %h instr %h, expected none", bus.pc, bus.instruction);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc", bus.pc, e.pc);
                    chk("instruction", bus.instruction, e.ins);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, bus.imem_req_valid}, 32'd0);
        chk({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        chk({tag, "_imem_addr"}, bus.imem_addr, RST_PC);
        chk({tag, "_pc"}, bus.pc, RST_PC);
        chk({tag, "_instruction"}, bus.instruction, 32'h0000_0013);
    endtask

    task automatic drain_and_check(input string tag);
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        step(16);
        chk({tag, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    int a0;

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0000_0000;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Stalled decode: only DEPTH requests may be accepted.
        step(1);
        a0 = acc_cnt;
        bus.imem_req_ready = 1'b1;
        step(10);
        @(negedge clk);
        chk("stall_accepted", acc_cnt - a0, 32'd2);
        chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);

        // Release decode: streaming from RESET_PC at latency 1.
        step(1);
        bus.instr_ready = 1'b1;
        step(30);

        // Latency 3 with requests in flight, then redirect.
        lat_min = 3;
        lat_max = 3;
        step(6);
        redirect_to(32'h0000_0200);
        step(20);
        drain_and_check("lat3");

        // Misaligned target and address wrap.
        lat_min = 1;
        lat_max = 1;
        redirect_to(32'h0000_0203);
        chk("align_addr", bus.imem_addr, 32'h0000_0200);
        chk("align_pc", bus.pc, 32'h0000_0200);
        bus.imem_req_ready = 1'b1;
        redirect_to(32'hFFFF_FFFC);
        step(1);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        step(10);

        // Redirects during steady flow, including back-to-back.
        step(8);
        redirect_to(32'h0000_0400);
        step(10);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0500;
        step(1);
        bus.redirect_pc    = 32'h0000_0602;
        step(1);
        bus.redirect_valid = 1'b0;
        step(12);
        drain_and_check("directed");

        // Randomized traffic.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.instr_ready    = ($urandom_range(3, 0) != 0);
            bus.redirect_valid = ($urandom_range(24, 0) == 0);
            if ($urandom_range(3, 0) == 0)
                bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
            else
                bus.redirect_pc = $urandom;
            step(1);
        end
        drain_and_check("random");

        // Reset mid-stream, then a stray response with nothing outstanding.
        lat_min = 3;
        lat_max = 3;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        step(5);
        #1;
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        #1;
        check_reset_outputs("midreset");
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        step(1);
        chk("restart_addr", bus.imem_addr, RST_PC);
        bus.imem_req_ready = 1'b1;
        step(20);
        drain_and_check("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
